uart_tx_fifo: RTL

Parametrised, buffered UART transmitter: the next generation of the serial transmit path. Accepts words over a valid/ready handshake into an internal FIFO and serialises them LSB-first. Data width, FIFO depth, baud select, parity mode and stop-bit count are configurable. Sits between the core's data producers and the serial pin, and pairs with the existing receiver on the same baud/parity settings.

---
 rtl/uart_pkg.sv | 48 ++++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/uart_tx_fifo.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART codes, divisor table and FSM encoding
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  localparam logic [2:0] BAUD_DIV1024 = 3'd0;
  localparam logic [2:0] BAUD_DIV512  = 3'd1;
  localparam logic [2:0] BAUD_DIV256  = 3'd2;
  localparam logic [2:0] BAUD_DIV128  = 3'd3;
  localparam logic [2:0] BAUD_DIV64   = 3'd4;
  localparam logic [2:0] BAUD_DIV32   = 3'd5;
  localparam logic [2:0] BAUD_DIV16   = 3'd6;
  localparam logic [2:0] FASTEST      = 3'd7;

  localparam int DIV_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Bit period in clk cycles for a given baud select code.
  function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
    logic [DIV_W-1:0] div;
    case (sel)
      BAUD_DIV1024: div = 11'd1024;
      BAUD_DIV512:  div = 11'd512;
      BAUD_DIV256:  div = 11'd256;
      BAUD_DIV128:  div = 11'd128;
      BAUD_DIV64:   div = 11'd64;
      BAUD_DIV32:   div = 11'd32;
      BAUD_DIV16:   div = 11'd16;
      default:      div = 11'd4;
    endcase
    return div;
  endfunction

  // True when the parity code selects a transmitted parity bit.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with valid/ready push and pop strobe
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Full/empty come from the registered count; a same-cycle pop does not free a slot.
  assign push_ready = (count_q != FULL_CNT);
  assign empty      = (count_q == '0);
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && !empty;
  assign pop_data   = mem_q[rd_ptr_q[AW-1:0]];
  assign count      = count_q;

  // Advance pointers; the wrap bit makes the pointer difference the fill level.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = wr_ptr_d - rd_ptr_d;
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; stale words after reset are unreachable because pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter with configurable frame format
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    baud_sel,
  input  logic [1:0]                    parity,
  input  logic                          stop_two,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  uart_state_e            state_q, state_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic [DIV_W-1:0]       baud_cnt_q, baud_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   par_en_q, par_en_d;
  logic                   par_bit_q, par_bit_d;
  logic                   stop_two_q, stop_two_d;

  logic [DATA_BITS-1:0]   fifo_data;
  logic                   fifo_empty;
  logic                   baud_last, stop_last, frame_end, pop;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetn     (reset),
    .push_data  (in_data),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .pop        (pop),
    .pop_data   (fifo_data),
    .count      (fifo_count),
    .empty      (fifo_empty)
  );

  assign baud_last = (baud_cnt_q == div_q - 11'd1);
  assign stop_last = !stop_two_q || (bit_cnt_q == 4'd1);
  assign frame_end = (state_q == ST_STOP) && baud_last && stop_last;
  assign pop       = ((state_q == ST_IDLE) || frame_end) && !fifo_empty;

  assign tx   = tx_q;
  assign busy = busy_q;

  // Serialiser next state: a pop loads a new frame and latches its line settings.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    baud_cnt_d = baud_cnt_q + 11'd1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop_two_d = stop_two_q;
    if (pop) begin
      state_d    = ST_START;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
      shift_d    = fifo_data;
      div_d      = baud_div(baud_sel);
      par_en_d   = parity_enabled(parity);
      par_bit_d  = (parity == PAR_ODD) ? ~(^fifo_data) : (^fifo_data);
      stop_two_d = stop_two;
    end else begin
      case (state_q)
        ST_START: begin
          if (baud_last) begin
            state_d    = ST_DATA;
            tx_d       = shift_q[0];
            shift_d    = shift_q >> 1;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud_cnt_d = '0;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              if (par_en_q) begin
                state_d = ST_PARITY;
                tx_d    = par_bit_q;
              end else begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              tx_d      = shift_q[0];
              shift_d   = shift_q >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (baud_last) begin
            state_d    = ST_STOP;
            tx_d       = 1'b1;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            baud_cnt_d = '0;
            if (stop_last) begin
              state_d   = ST_IDLE;
              busy_d    = 1'b0;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          tx_d       = 1'b1;
          busy_d     = 1'b0;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      endcase
    end
  end

  // Serialiser registers; reset returns the line to idle mid-frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      div_q      <= baud_div(FASTEST);
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_two_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop_two_q <= stop_two_d;
    end
  end

endmodule
